// File: rtl/imm_encoder.sv
// RV32I instruction packer: places an immediate and register/opcode fields into a 32-bit word
// behind a single output register stage, flagging immediates the selected format cannot hold.
package imm_pkg;
    localparam logic [2:0] ITYPE = 3'd0;
    localparam logic [2:0] STYPE = 3'd1;
    localparam logic [2:0] BTYPE = 3'd2;
    localparam logic [2:0] UTYPE = 3'd3;
    localparam logic [2:0] JTYPE = 3'd4;
endpackage

module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_ctrl,
    input  logic [31:0]      imm,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err_range,
    output logic             err_align,
    output logic             err_fmt,
    output logic [CNT_W-1:0] err_count
);

    logic             valid_q;
    logic [31:0]      instr_q, instr_d;
    logic             range_q, range_d;
    logic             align_q, align_d;
    logic             fmt_q, fmt_d;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             any_err;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign any_err  = range_d || align_d || fmt_d;

    // A value fits in N signed bits when every bit from N-1 upward equals the sign bit.
    always_comb begin
        instr_d = {25'b0, opcode};
        range_d = 1'b0;
        align_d = 1'b0;
        fmt_d   = 1'b0;
        case (imm_ctrl)
            ITYPE: begin
                instr_d = {imm[11:0], rs1, funct3, rd, opcode};
                range_d = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            STYPE: begin
                instr_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_d = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            BTYPE: begin
                instr_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_d = (imm[31:12] != '0) && (imm[31:12] != '1);
                align_d = imm[0];
            end
            UTYPE: begin
                instr_d = {imm[31:12], rd, opcode};
                align_d = |imm[11:0];
            end
            JTYPE: begin
                instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_d = (imm[31:20] != '0) && (imm[31:20] != '1);
                align_d = imm[0];
            end
            default: fmt_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            range_q <= 1'b0;
            align_q <= 1'b0;
            fmt_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                instr_q <= instr_d;
                range_q <= range_d;
                align_q <= align_d;
                fmt_q   <= fmt_d;
                if (any_err && (count_q != {CNT_W{1'b1}}))
                    count_q <= count_q + 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign instr     = instr_q;
    assign err_range = range_q;
    assign err_align = align_q;
    assign err_fmt   = fmt_q;
    assign err_count = count_q;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction-packing block for the RV32I datapath: accepts an immediate value, a format select and register/opcode fields, and assembles the 32-bit instruction word. It is the encode-side counterpart of the decode-stage immediate extender and shares its `imm_ctrl` format encoding. It feeds the debug/boot instruction-injection path, registers its output behind a valid/ready handshake, and flags immediates that cannot be represented in the selected format.

## Interface

Parameters:
- `CNT_W`, 16, width of the saturating error counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request this cycle
- `imm_ctrl`  in  3  format select; package constants ITYPE/STYPE/BTYPE/UTYPE/JTYPE, any other code is illegal
- `imm`  in  32  signed immediate (byte offset for B/J; full upper value for U)
- `opcode`  in  7  instr[6:0]
- `rd`, `rs1`, `rs2`  in  5 each  register fields
- `funct3`  in  3  instr[14:12]
- `out_valid`  out  1  `instr` holds an encoded word
- `out_ready`  in  1  consumer accepts the word
- `instr`  out  32  encoded instruction
- `err_range`  out  1  immediate outside the format's range (qualified by `out_valid`)
- `err_align`  out  1  immediate low bits nonzero where required zero (qualified by `out_valid`)
- `err_fmt`  out  1  illegal `imm_ctrl` (qualified by `out_valid`)
- `err_count`  out  CNT_W  number of accepted requests with any error; saturates at all-ones

## Operation

- Field placement (unused positions are 0):
  - `opcode` always goes to [6:0].
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12], [11:7]=rd.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
- Range checks, with `imm` treated as signed 32-bit:
  - I/S: −2048..2047.
  - B: −4096..4095.
  - J: −1048576..1048575.
  - U: never a range error.
- Alignment checks:
  - B/J: imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - I/S: never an alignment error.
- Illegal `imm_ctrl`:
  - `instr` is `{25'b0, opcode}`.
  - `err_fmt`=1; `err_range`=`err_align`=0.
- Errors do not block output. The truncated encoding is still emitted with the error flags set.
- `err_count` increments by 1 on each accepted request whose err_range|err_align|err_fmt would be set.
  - It holds at 2^CNT_W−1 once reached.
  - It is only cleared by reset.

## Timing

- One output register stage.
- A request accepted on edge N (`in_valid && in_ready`) gives `out_valid`=1 with `instr` and the error flags stable from after edge N until the word is accepted.
- `in_ready` = `!out_valid || out_ready` (combinational).
  - Full throughput is one word per cycle while `out_ready`=1.
  - There is no combinational path from `in_valid` to `out_valid`.
- Stall: while `out_valid && !out_ready`, `instr` and the error flags hold and inputs are ignored.
- Simultaneous accept and output handshake: the new word replaces the old one on the same edge and `out_valid` stays 1.
- Output accepted with no new input: `out_valid` → 0 on the next edge. `instr` and the flags then hold their last values, which are don't-care.
- `err_count` updates on the accept edge, so it is visible in the same cycle the erroneous word first shows `out_valid`.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - `out_valid`=0, `instr`=0, all err flags=0, `err_count`=0.
  - An in-flight word is discarded.
  - `in_ready`=1 during and after reset.

## Test plan

- ITYPE, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 → `instr`=0x00500093, no errors, `out_valid` one cycle after accept.
- STYPE, opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8 → 0x0020A423. Then BTYPE, opcode=0x63, all regs 0, funct3=0, imm=−4 → 0xFE000EE3.
- JTYPE, opcode=0x6F, rd=1, imm=16 → 0x010000EF. UTYPE, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- Errors:
  - ITYPE imm=2048 → `err_range`=1, `instr`[31:20]=0x800.
  - JTYPE imm=3 → `err_align`=1.
  - `imm_ctrl`=7 → `err_fmt`=1, `instr`=`{25'b0, opcode}`.
  - `err_count` reaches 3 after the three requests.
- Back-to-back stream of 4 words with `out_ready` low for 2 cycles mid-stream → no word lost or duplicated, `instr` stable while stalled, `in_ready`=0 during the stall.
- Assert `rst_n`=0 while `out_valid`=1 and stalled → `out_valid`, `instr`, flags and `err_count` go to 0 immediately; the first request after release encodes correctly.
